// File: rtl/branch_predictor_pkg.sv
// Shared CPU definitions used by the branch predictor: default datapath width,
// instruction length and the 2-bit direction counter encodings.
package branch_predictor_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_LEN    = 4;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } bht_cnt_e;

    // The upper bit of the counter is the taken/not-taken prediction.
    function automatic logic cnt_predicts_taken(input bht_cnt_e cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bht_cnt_e cnt_i,
    input  logic     taken_i,
    output bht_cnt_e cnt_next_o
);

    always_comb begin
        cnt_next_o = cnt_i;
        case (cnt_i)
            CNT_STRONG_NT: cnt_next_o = taken_i ? CNT_WEAK_NT  : CNT_STRONG_NT;
            CNT_WEAK_NT:   cnt_next_o = taken_i ? CNT_WEAK_T   : CNT_STRONG_NT;
            CNT_WEAK_T:    cnt_next_o = taken_i ? CNT_STRONG_T : CNT_WEAK_NT;
            CNT_STRONG_T:  cnt_next_o = taken_i ? CNT_STRONG_T : CNT_WEAK_T;
            default:       cnt_next_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// saturating resolved-branch / mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  lookup_pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             upd_mispredict_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int INDEX_W = $clog2(ENTRIES);

    // Update port: upd_valid_i qualifies all upd_* fields for exactly one
    // cycle; there is no ready, the table always accepts when start_i is high.

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    bht_cnt_e          cnt_q    [ENTRIES];

    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  mispredict_cnt_q;

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_accept;
    logic               up_hit;
    bht_cnt_e           up_cnt_next;
    logic               unused_upd_pc;

    assign lk_idx = lookup_pc_i[INDEX_W+1:2];
    assign lk_tag = lookup_pc_i[INDEX_W+2 +: TAG_W];
    assign up_idx = upd_pc_i[INDEX_W+1:2];
    assign up_tag = upd_pc_i[INDEX_W+2 +: TAG_W];

    // Byte-offset and bits above the tag do not take part in indexing.
    assign unused_upd_pc = ^upd_pc_i;

    assign up_accept = upd_valid_i && start_i;
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads registered state only, so a same-cycle update is not seen.
    always_comb begin
        pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = pred_hit_o && cnt_predicts_taken(cnt_q[lk_idx]);
        pred_target_o = pred_taken_o ? target_q[lk_idx]
                                     : lookup_pc_i + XLEN'(INSTR_LEN);
    end

    sat_counter2 u_sat_counter2 (
        .cnt_i      (cnt_q[up_idx]),
        .taken_i    (upd_taken_i),
        .cnt_next_o (up_cnt_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (up_accept) begin
            if (up_hit) begin
                cnt_q[up_idx] <= up_cnt_next;
                if (upd_taken_i) begin
                    target_q[up_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                cnt_q[up_idx]    <= CNT_WEAK_T;
            end
        end
    end

    // Statistics count accepted updates even when a flush suppresses them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (up_accept) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (upd_mispredict_i && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with a queue of expected
// {hit, taken, target} lookup results and tracked statistics values.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 4;
    localparam int W       = XLEN + 2;
    localparam int CNT_MAX = 15;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             flush_i;
    logic [XLEN-1:0]  lookup_pc_i;
    logic             pred_hit_o;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic             upd_valid_i;
    logic [XLEN-1:0]  upd_pc_i;
    logic             upd_taken_i;
    logic [XLEN-1:0]  upd_target_i;
    logic             upd_mispredict_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    logic [W-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int exp_branch = 0;
    int exp_misp   = 0;

    branch_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .flush_i          (flush_i),
        .lookup_pc_i      (lookup_pc_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_mispredict_i (upd_mispredict_i),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_update(input logic v, input logic [XLEN-1:0] pc,
                                input logic tk, input logic [XLEN-1:0] tgt,
                                input logic mp);
        upd_valid_i      = v;
        upd_pc_i         = pc;
        upd_taken_i      = tk;
        upd_target_i     = tgt;
        upd_mispredict_i = mp;
    endtask

    task automatic idle_update();
        drive_update(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic push_exp(input logic hit, input logic tk, input logic [XLEN-1:0] tgt);
        exp_q.push_back({hit, tk, tgt});
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] obs, exp;
        logic [XLEN-1:0] rpc;
        rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; lookup_pc_i = '0;
        idle_update();
        step(); step();
        rst_i = 1'b0;
        lookup_pc_i = 32'h40;
        push_exp(1'b0, 1'b0, 32'h44);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL reset_lookup: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 4; i++) begin
            rpc = $urandom;
            lookup_pc_i = rpc;
            push_exp(1'b0, 1'b0, rpc + 32'd4);
            #1;
            obs = {pred_hit_o, pred_taken_o, pred_target_o};
            exp = exp_q.pop_front();
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL reset_random_lookup: pc %h got %h expected %h", rpc, obs, exp);
            end
        end
        compared++;
        if (branch_cnt_o !== 4'd0 || mispredict_cnt_o !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    task automatic test_alloc();
        logic [W-1:0] obs, exp;
        drive_update(1'b1, 32'h40, 1'b1, 32'h20, 1'b1);
        lookup_pc_i = 32'h40;
        push_exp(1'b0, 1'b0, 32'h44);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alloc_same_cycle: got %h expected %h", obs, exp);
        end
        step();
        exp_branch = sat_inc(exp_branch);
        exp_misp   = sat_inc(exp_misp);
        idle_update();
        push_exp(1'b1, 1'b1, 32'h20);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alloc_next_cycle: got %h expected %h", obs, exp);
        end
        lookup_pc_i = 32'h43;
        push_exp(1'b1, 1'b1, 32'h20);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alloc_byte_offset: got %h expected %h", obs, exp);
        end
        compared++;
        if (branch_cnt_o !== CNT_W'(exp_branch) || mispredict_cnt_o !== CNT_W'(exp_misp)) begin
            mismatched++;
            $display("FAIL alloc_stats: got %0d/%0d expected %0d/%0d",
                     branch_cnt_o, mispredict_cnt_o, exp_branch, exp_misp);
        end
    endtask

    task automatic test_alias();
        logic [W-1:0] obs, exp;
        lookup_pc_i = 32'h80;
        push_exp(1'b0, 1'b0, 32'h84);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alias_miss: got %h expected %h", obs, exp);
        end
        drive_update(1'b1, 32'h80, 1'b1, 32'h100, 1'b1);
        step();
        exp_branch = sat_inc(exp_branch);
        exp_misp   = sat_inc(exp_misp);
        idle_update();
        lookup_pc_i = 32'h40;
        push_exp(1'b0, 1'b0, 32'h44);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alias_evicted: got %h expected %h", obs, exp);
        end
        lookup_pc_i = 32'h80;
        push_exp(1'b1, 1'b1, 32'h100);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL alias_new_entry: got %h expected %h", obs, exp);
        end
    endtask

    // Entry 0x80 starts at weak-taken with target 0x100.
    task automatic test_saturation();
        logic [W-1:0] obs, exp;
        logic            tk     [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [XLEN-1:0] tgt    [9] = '{32'h3C0, 32'h3C0, 32'h3C0, 32'h200, 32'h300,
                                        32'h300, 32'h300, 32'h3C0, 32'h3C0};
        logic            e_tk   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [XLEN-1:0] e_tgt  [9] = '{32'h84, 32'h84, 32'h84, 32'h84, 32'h300,
                                        32'h300, 32'h300, 32'h300, 32'h84};
        for (int i = 0; i < 9; i++) begin
            drive_update(1'b1, 32'h80, tk[i], tgt[i], 1'b0);
            step();
            exp_branch = sat_inc(exp_branch);
            idle_update();
            lookup_pc_i = 32'h80;
            push_exp(1'b1, e_tk[i], e_tgt[i]);
            #1;
            obs = {pred_hit_o, pred_taken_o, pred_target_o};
            exp = exp_q.pop_front();
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL saturation_step%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_flush_start();
        logic [W-1:0] obs, exp;
        logic [XLEN-1:0] pcs [3] = '{32'h40, 32'h80, 32'hC0};
        flush_i = 1'b1;
        drive_update(1'b1, 32'hC0, 1'b1, 32'h500, 1'b1);
        step();
        exp_branch = sat_inc(exp_branch);
        exp_misp   = sat_inc(exp_misp);
        flush_i = 1'b0;
        idle_update();
        for (int i = 0; i < 3; i++) begin
            lookup_pc_i = pcs[i];
            push_exp(1'b0, 1'b0, pcs[i] + 32'd4);
            #1;
            obs = {pred_hit_o, pred_taken_o, pred_target_o};
            exp = exp_q.pop_front();
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL flush_lookup_%h: got %h expected %h", pcs[i], obs, exp);
            end
        end
        compared++;
        if (branch_cnt_o !== CNT_W'(exp_branch) || mispredict_cnt_o !== CNT_W'(exp_misp)) begin
            mismatched++;
            $display("FAIL flush_stats: got %0d/%0d expected %0d/%0d",
                     branch_cnt_o, mispredict_cnt_o, exp_branch, exp_misp);
        end
        start_i = 1'b0;
        drive_update(1'b1, 32'hC0, 1'b1, 32'h600, 1'b1);
        step();
        start_i = 1'b1;
        // upd_* garbage with valid low must be ignored.
        drive_update(1'b0, 32'hC0, 1'b1, 32'h700, 1'b1);
        step();
        idle_update();
        lookup_pc_i = 32'hC0;
        push_exp(1'b0, 1'b0, 32'hC4);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL frozen_lookup: got %h expected %h", obs, exp);
        end
        compared++;
        if (branch_cnt_o !== CNT_W'(exp_branch) || mispredict_cnt_o !== CNT_W'(exp_misp)) begin
            mismatched++;
            $display("FAIL frozen_stats: got %0d/%0d expected %0d/%0d",
                     branch_cnt_o, mispredict_cnt_o, exp_branch, exp_misp);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] obs, exp;
        drive_update(1'b1, 32'h40, 1'b1, 32'h20, 1'b1);
        step();
        rst_i = 1'b1;
        drive_update(1'b1, 32'h80, 1'b1, 32'h100, 1'b1);
        step();
        rst_i = 1'b0;
        idle_update();
        exp_branch = 0;
        exp_misp   = 0;
        lookup_pc_i = 32'h40;
        push_exp(1'b0, 1'b0, 32'h44);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL reset_mid_0x40: got %h expected %h", obs, exp);
        end
        lookup_pc_i = 32'h80;
        push_exp(1'b0, 1'b0, 32'h84);
        #1;
        obs = {pred_hit_o, pred_taken_o, pred_target_o};
        exp = exp_q.pop_front();
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL reset_mid_0x80: got %h expected %h", obs, exp);
        end
        compared++;
        if (branch_cnt_o !== 4'd0 || mispredict_cnt_o !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_mid_stats: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    // Back-to-back mispredicted updates drive both counters into saturation.
    task automatic test_stats_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive_update(1'b1, 32'h40 + 32'($urandom_range(0, 15) << 2),
                         1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) << 2), 1'b1);
            step();
            exp_branch = sat_inc(exp_branch);
            exp_misp   = sat_inc(exp_misp);
            compared++;
            if (branch_cnt_o !== CNT_W'(exp_branch) || mispredict_cnt_o !== CNT_W'(exp_misp)) begin
                mismatched++;
                $display("FAIL stats_update%0d: got %0d/%0d expected %0d/%0d", i,
                         branch_cnt_o, mispredict_cnt_o, exp_branch, exp_misp);
            end
        end
        idle_update();
        compared++;
        if (branch_cnt_o !== 4'd15 || mispredict_cnt_o !== 4'd15) begin
            mismatched++;
            $display("FAIL stats_saturated: got %0d/%0d expected 15/15", branch_cnt_o, mispredict_cnt_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alloc();
        test_alias();
        test_saturation();
        test_flush_start();
        test_reset_mid();
        test_stats_back_to_back();
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, required completion before it");
        $fatal(1, "watchdog expired");
    end

endmodule
